mux_rr_nto1: RTL and testbench

MUX_RR_NTO1 -- requirements
Module: mux_rr_nto1

---
 rtl/mux_rr_nto1.sv | 135 +++++++++++++
 tb/tb_mux_rr_nto1.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_nto1.sv
// mux_rr_nto1: N-to-1 registered multiplexer with two selection modes.
//   mode=0: direct select by 'sel', qualified by 'in_valid'.
//   mode=1: round-robin arbitration over 'req', starting the search at ptr.
// The output stage is a single register with valid/ready handshaking.
//
// Handshake: a word is transferred downstream on every rising edge where
// out_valid=1 and out_ready=1. A new word is captured (load) whenever a
// candidate is present and the output register is empty or being drained
// in the same cycle. While out_valid=1 and out_ready=0 the output word is
// held and no grant is issued. 'grant' is the combinational one-hot of the
// channel captured at the coming edge, so a channel is consumed exactly in
// a cycle in which its grant bit is high.
module mux_rr_nto1 #(
  parameter int WIDTH = 3,
  parameter int N     = 8,
  parameter int SELW  = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N*WIDTH-1:0] data_in,
  input  logic [N-1:0]       req,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic               in_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid,
  output logic [SELW-1:0]    out_src,
  output logic [N-1:0]       grant
);

  // Registered state.
  logic [WIDTH-1:0] out_q,       out_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  out_src_q,   out_src_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  // Selection datapath.
  logic [2*N-1:0]   req_rot;
  logic             rr_found;
  logic [SELW-1:0]  rr_idx;
  logic [SELW-1:0]  dir_idx;
  logic [SELW-1:0]  sel_idx;
  logic [WIDTH-1:0] sel_data;
  logic             cand;
  logic             load;
  logic [N-1:0]     grant_d;

  // (base + off) mod N, for base in 0..N-1 and off in 0..N.
  function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return SELW'(s);
  endfunction

  // Rotate requests so that bit 0 corresponds to channel ptr.
  assign req_rot = {req, req} >> ptr_q;

  // Round-robin search: first request at ptr, ptr+1, ... with wrap-around.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!rr_found && req_rot[k]) begin
        rr_found = 1'b1;
        rr_idx   = wrap_add(ptr_q, k);
      end
    end
  end

  // Direct select: out-of-range indices fall back to channel 0.
  always_comb begin
    dir_idx = '0;
    if (int'(sel) < N) dir_idx = sel;
  end

  // Mode-dependent candidate, selected index, and load condition.
  always_comb begin
    sel_idx = mode ? rr_idx : dir_idx;
    cand    = mode ? rr_found : in_valid;
    load    = cand && (!out_valid_q || out_ready);
  end

  // Data mux over channels using constant slices.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (SELW'(k) == sel_idx) sel_data = data_in[k*WIDTH +: WIDTH];
    end
  end

  // Grant is suppressed while reset is asserted.
  always_comb begin
    grant_d = '0;
    if (load && reset_n) grant_d = N'(1) << sel_idx;
  end

  // Next-state for the output register and the round-robin pointer.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_d       = sel_data;
      out_src_d   = sel_idx;
      out_valid_d = 1'b1;
      if (mode) ptr_d = wrap_add(sel_idx, 1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;
  assign grant     = grant_d;

endmodule

// File: tb/tb_mux_rr_nto1.sv
// Testbench for mux_rr_nto1: directed scenarios plus randomized traffic
// checked against a behavioural model and an expected-word queue.
module tb_mux_rr_nto1;
  localparam int N     = 8;
  localparam int WIDTH = 3;
  localparam int SELW  = 3;
  localparam int N6    = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // ---------------- DUT (N=8) ----------------
  logic [N*WIDTH-1:0] data_in;
  logic [N-1:0]       req;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic               in_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out;
  logic               out_valid;
  logic [SELW-1:0]    out_src;
  logic [N-1:0]       grant;

  mux_rr_nto1 #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .req(req), .mode(mode),
    .sel(sel), .in_valid(in_valid), .out_ready(out_ready), .out(out),
    .out_valid(out_valid), .out_src(out_src), .grant(grant)
  );

  // ---------------- DUT (N=6) for out-of-range select ----------------
  logic [N6*WIDTH-1:0] data6;
  logic [N6-1:0]       req6;
  logic                mode6;
  logic [SELW-1:0]     sel6;
  logic                in_valid6;
  logic                out_ready6;
  logic [WIDTH-1:0]    out6;
  logic                out_valid6;
  logic [SELW-1:0]     out_src6;
  logic [N6-1:0]       grant6;

  mux_rr_nto1 #(.WIDTH(WIDTH), .N(N6), .SELW(SELW)) dut6 (
    .clk(clk), .reset_n(reset_n), .data_in(data6), .req(req6), .mode(mode6),
    .sel(sel6), .in_valid(in_valid6), .out_ready(out_ready6), .out(out6),
    .out_valid(out_valid6), .out_src(out_src6), .grant(grant6)
  );

  // ---------------- counters / scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];

  // ---------------- reference model ----------------
  int               m_ptr;
  logic [WIDTH-1:0] m_out;
  logic             m_valid;
  int               m_src;

  function automatic logic [WIDTH-1:0] chan(input int i);
    return data_in[i*WIDTH +: WIDTH];
  endfunction

  // Lowest requesting index at or above ptr, otherwise lowest overall.
  function automatic int rr_pick(input int p, input logic [N-1:0] r);
    for (int i = p; i < N; i++) if (r[i]) return i;
    for (int i = 0; i < p; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_out = '0; m_valid = 1'b0; m_src = 0;
  endtask

  // Predict the coming edge from current inputs and model state.
  task automatic model_expect(output logic [N-1:0] g, output logic ld, output int idx);
    logic present;
    if (mode) begin
      idx     = rr_pick(m_ptr, req);
      present = (idx >= 0);
    end else begin
      idx     = (int'(sel) < N) ? int'(sel) : 0;
      present = in_valid;
    end
    ld = present && (!m_valid || out_ready);
    g  = '0;
    if (ld) g[idx] = 1'b1;
  endtask

  task automatic model_commit(input logic ld, input int idx);
    if (ld) begin
      m_out   = chan(idx);
      m_src   = idx;
      m_valid = 1'b1;
      if (mode) m_ptr = (idx + 1) % N;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_channels_index();
    for (int i = 0; i < N; i++) data_in[i*WIDTH +: WIDTH] = WIDTH'(i);
  endtask

  task automatic set_channels_random();
    for (int i = 0; i < N; i++) data_in[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 7));
  endtask

  task automatic idle_inputs();
    req = '0; mode = 1'b0; sel = '0; in_valid = 1'b0; out_ready = 1'b0;
    req6 = '0; mode6 = 1'b0; sel6 = '0; in_valid6 = 1'b0; out_ready6 = 1'b0;
    data6 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    set_channels_index();
    reset_n = 1'b0;
    mode = 1'b1; req = '1; out_ready = 1'b1;
    #1;
    total++;
    if (grant !== '0 || out !== '0 || out_valid !== 1'b0 || out_src !== '0 || dut.ptr_q !== '0) begin
      bad++;
      $display("FAIL reset_state: grant=%h out=%0d valid=%b src=%0d ptr=%0d, want all 0",
               grant, out, out_valid, out_src, dut.ptr_q);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || grant !== '0) begin
      bad++;
      $display("FAIL reset_no_load: valid=%b grant=%h, want 0/00", out_valid, grant);
    end
    do_reset();
  endtask

  task automatic test_async_reset();
    do_reset();
    set_channels_index();
    mode = 1'b0; sel = 3'd3; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1 || out !== 3'd3) begin
      bad++;
      $display("FAIL async_setup: valid=%b out=%0d, want 1/3", out_valid, out);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (out !== '0 || out_valid !== 1'b0 || out_src !== '0 || grant !== '0) begin
      bad++;
      $display("FAIL async_reset: out=%0d valid=%b src=%0d grant=%h, want 0", out, out_valid, out_src, grant);
    end
    do_reset();
  endtask

  task automatic test_direct();
    do_reset();
    set_channels_index();
    mode = 1'b0; sel = 3'd5; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    total++;
    if (grant !== 8'b0010_0000) begin
      bad++;
      $display("FAIL direct_grant: got %b want 00100000", grant);
    end
    @(posedge clk); #1;
    total++;
    if (out !== 3'd5 || out_src !== 3'd5 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL direct_out: out=%0d src=%0d valid=%b, want 5/5/1", out, out_src, out_valid);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL direct_drain: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_n6_out_of_range();
    do_reset();
    for (int i = 0; i < N6; i++) data6[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
    mode6 = 1'b0; sel6 = 3'd7; in_valid6 = 1'b1; out_ready6 = 1'b1;
    #1;
    total++;
    if (grant6 !== 6'b00_0001) begin
      bad++;
      $display("FAIL n6_grant: got %b want 000001", grant6);
    end
    @(posedge clk); #1;
    total++;
    if (out6 !== 3'd1 || out_src6 !== 3'd0 || out_valid6 !== 1'b1) begin
      bad++;
      $display("FAIL n6_out: out=%0d src=%0d valid=%b, want 1/0/1", out6, out_src6, out_valid6);
    end
    in_valid6 = 1'b0;
  endtask

  task automatic test_rr_wrap();
    int exp_src;
    do_reset();
    set_channels_random();
    mode = 1'b1; req = 8'b1000_0001; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      exp_src = (c % 2 == 0) ? 0 : 7;
      #1;
      total++;
      if (grant !== (N'(1) << exp_src)) begin
        bad++;
        $display("FAIL rr_wrap_grant[%0d]: got %b want bit %0d", c, grant, exp_src);
      end
      @(posedge clk); #1;
      total++;
      if (int'(out_src) !== exp_src || out !== chan(exp_src) || out_valid !== 1'b1 ||
          int'(dut.ptr_q) !== (exp_src + 1) % N) begin
        bad++;
        $display("FAIL rr_wrap[%0d]: src=%0d out=%0d ptr=%0d, want src=%0d out=%0d ptr=%0d",
                 c, out_src, out, dut.ptr_q, exp_src, chan(exp_src), (exp_src + 1) % N);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] held;
    do_reset();
    set_channels_random();
    mode = 1'b1; req = 8'hFF; out_ready = 1'b1;
    @(posedge clk); #1;
    held = chan(0);
    total++;
    if (out_src !== 3'd0 || out !== held || dut.ptr_q !== 3'd1) begin
      bad++;
      $display("FAIL bp_first: src=%0d out=%0d ptr=%0d, want 0/%0d/1", out_src, out, dut.ptr_q, held);
    end
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (grant !== '0) begin
        bad++;
        $display("FAIL bp_grant[%0d]: got %b want 0", c, grant);
      end
      @(posedge clk); #1;
      total++;
      if (out !== held || out_src !== 3'd0 || out_valid !== 1'b1 || dut.ptr_q !== 3'd1) begin
        bad++;
        $display("FAIL bp_hold[%0d]: out=%0d src=%0d valid=%b ptr=%0d, want %0d/0/1/1",
                 c, out, out_src, out_valid, dut.ptr_q, held);
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (grant !== 8'h02) begin
      bad++;
      $display("FAIL bp_release_grant: got %b want 00000010", grant);
    end
    @(posedge clk); #1;
    total++;
    if (out_src !== 3'd1 || out !== chan(1) || dut.ptr_q !== 3'd2) begin
      bad++;
      $display("FAIL bp_release: src=%0d out=%0d ptr=%0d, want 1/%0d/2", out_src, out, dut.ptr_q, chan(1));
    end
  endtask

  task automatic test_mode_switch();
    do_reset();
    set_channels_index();
    mode = 1'b1; req = 8'h04; out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_src !== 3'd2 || dut.ptr_q !== 3'd3) begin
      bad++;
      $display("FAIL ms_rr: src=%0d ptr=%0d, want 2/3", out_src, dut.ptr_q);
    end
    mode = 1'b0; req = '0; sel = 3'd6; in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      total++;
      if (out_src !== 3'd6 || out !== 3'd6 || dut.ptr_q !== 3'd3) begin
        bad++;
        $display("FAIL ms_direct[%0d]: src=%0d out=%0d ptr=%0d, want 6/6/3", c, out_src, out, dut.ptr_q);
      end
    end
    mode = 1'b1; req = 8'hFF; in_valid = 1'b0;
    #1;
    total++;
    if (grant !== 8'h08) begin
      bad++;
      $display("FAIL ms_back_grant: got %b want 00001000", grant);
    end
    @(posedge clk); #1;
    total++;
    if (out_src !== 3'd3 || dut.ptr_q !== 3'd4) begin
      bad++;
      $display("FAIL ms_back: src=%0d ptr=%0d, want 3/4", out_src, dut.ptr_q);
    end
  endtask

  task automatic test_random();
    logic [N-1:0]     g;
    logic             ld;
    int               idx;
    logic [WIDTH-1:0] exp_word;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      set_channels_random();
      req       = N'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) req = '0;
      mode      = 1'($urandom_range(0, 1));
      sel       = SELW'($urandom_range(0, 7));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      model_expect(g, ld, idx);
      total++;
      if (grant !== g) begin
        bad++;
        $display("FAIL rand_grant[%0d]: got %b want %b", c, grant, g);
      end
      if (m_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rand_consume[%0d]: out=%0d but no word expected", c, out);
        end else begin
          exp_word = exp_q.pop_front();
          if (out !== exp_word) begin
            bad++;
            $display("FAIL rand_consume[%0d]: out=%0d want %0d", c, out, exp_word);
          end
        end
      end
      @(posedge clk);
      model_commit(ld, idx);
      if (ld) exp_q.push_back(m_out);
      #1;
      total++;
      if (out_valid !== m_valid || (m_valid && (out !== m_out || int'(out_src) !== m_src)) ||
          int'(dut.ptr_q) !== m_ptr) begin
        bad++;
        $display("FAIL rand_state[%0d]: valid=%b out=%0d src=%0d ptr=%0d, want %b/%0d/%0d/%0d",
                 c, out_valid, out, out_src, dut.ptr_q, m_valid, m_out, m_src, m_ptr);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    reset_n = 1'b0;
    data_in = '0;
    idle_inputs();
    model_reset();
    test_reset();
    test_async_reset();
    test_direct();
    test_n6_out_of_range();
    test_rr_wrap();
    test_backpressure();
    test_mode_switch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
